// File: rtl/demux_1to4_pkg.sv
// Shared constants for the 1-to-4 demultiplexer and its channel counters.
package demux_1to4_pkg;

  localparam int N_OUT     = 4;
  localparam int SEL_W     = 2;
  localparam int CNT_W_DEF = 8;

endpackage

// File: rtl/demux_1to4_dec.sv
// Combinational decoder steering din onto the output line picked by sel.
module demux_1to4_dec
  import demux_1to4_pkg::*;
(
  input  logic             din_i,
  input  logic [SEL_W-1:0] sel_i,
  output logic [N_OUT-1:0] y_o
);

  // Route din to the selected line; every other line is held low.
  always_comb begin
    y_o = {N_OUT{1'b0}};
    case (sel_i)
      2'b00:   y_o = {3'b000, din_i};
      2'b01:   y_o = {2'b00, din_i, 1'b0};
      2'b10:   y_o = {1'b0, din_i, 2'b00};
      2'b11:   y_o = {din_i, 3'b000};
      default: y_o = {N_OUT{1'b0}};
    endcase
  end

endmodule

// File: rtl/demux_1to4.sv
// 1-to-4 demux with a registered copy of the output and saturating
// per-channel activity counters.
module demux_1to4
  import demux_1to4_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   din,
  input  logic [SEL_W-1:0]       sel,
  input  logic                   cnt_clr,
  output logic [N_OUT-1:0]       y,
  output logic [N_OUT-1:0]       y_q,
  output logic [N_OUT*CNT_W-1:0] ch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);

  logic [N_OUT-1:0] y_q_d;

  demux_1to4_dec u_dec (
    .din_i (din),
    .sel_i (sel),
    .y_o   (y)
  );

  assign y_q_d = y;

  // Registered copy of the decoder output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q <= {N_OUT{1'b0}};
    end else begin
      y_q <= y_q_d;
    end
  end

  for (genvar i = 0; i < N_OUT; i++) begin : g_ch
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear beats increment; a line-active cycle bumps the count until it saturates.
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
        cnt_d = CNT_ZERO;
      end else if (y[i] && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end

    // Channel activity counter state.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= CNT_ZERO;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign ch_cnt[i*CNT_W +: CNT_W] = cnt_q;
  end

endmodule

// File: tb/tb_demux_1to4.sv
// Self-checking bench for demux_1to4: directed sweeps plus randomized
// cycles against an arithmetic reference model.
module tb_demux_1to4;

  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          din;
  logic [1:0]    sel;
  logic          cnt_clr;
  logic [3:0]    y;
  logic [3:0]    y_q;
  logic [4*CW-1:0] ch_cnt;

  int n_checks = 0;
  int n_err    = 0;

  int         mdl_cnt [4];
  logic [3:0] mdl_yq;

  demux_1to4 #(.CNT_W(CW)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .sel     (sel),
    .cnt_clr (cnt_clr),
    .y       (y),
    .y_q     (y_q),
    .ch_cnt  (ch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_y(input logic d, input logic [1:0] s);
    int v;
    v = d ? (1 << int'(s)) : 0;
    return v[3:0];
  endfunction

  function automatic logic [31:0] mdl_packed();
    logic [31:0] p;
    p = 32'd0;
    for (int i = 0; i < 4; i++) begin
      p = p | (32'(mdl_cnt[i]) << (i * CW));
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mdl_cnt[i] = 0;
    mdl_yq = 4'b0000;
  endtask

  // One rising edge: advance the model with the inputs present at the edge, then compare.
  task automatic step(input string tag);
    @(posedge clk);
    if (cnt_clr) begin
      for (int i = 0; i < 4; i++) mdl_cnt[i] = 0;
    end else if (din) begin
      if (mdl_cnt[sel] < CMAX) mdl_cnt[sel] = mdl_cnt[sel] + 1;
    end
    mdl_yq = exp_y(din, sel);
    #1;
    check({tag, "_yq"}, 32'(y_q), 32'(mdl_yq));
    check({tag, "_cnt"}, ch_cnt, mdl_packed());
  endtask

  logic       sw_din [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] sw_sel [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
  logic [3:0] sw_exp [6] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0000};

  initial begin
    rst_n   = 1'b0;
    din     = 1'b0;
    sel     = 2'b00;
    cnt_clr = 1'b0;
    model_reset();
    #3;
    check("rst_yq", 32'(y_q), 32'd0);
    check("rst_cnt", ch_cnt, 32'd0);

    // Combinational sweep while still in reset: y must not care.
    for (int k = 0; k < 6; k++) begin
      din = sw_din[k];
      sel = sw_sel[k];
      #10;
      check($sformatf("comb_%0d", k), 32'(y), 32'(sw_exp[k]));
    end
    rst_n = 1'b1;

    // Registered lag.
    din = 1'b1; sel = 2'b10;
    step("lag_hi");
    check("lag_hi_const", 32'(y_q), 32'h4);
    din = 1'b0;
    step("lag_lo");
    check("lag_lo_const", 32'(y_q), 32'h0);

    cnt_clr = 1'b1;
    step("pre_clr");
    cnt_clr = 1'b0;

    // Counting on channel 1, then clear beats a simultaneous increment.
    din = 1'b1; sel = 2'b01;
    for (int k = 0; k < 5; k++) step("count");
    check("count5_const", ch_cnt, 32'h0000_0500);
    cnt_clr = 1'b1;
    step("clr_wins");
    check("clr_wins_const", ch_cnt, 32'd0);
    cnt_clr = 1'b0;

    // Saturation on channel 3.
    sel = 2'b11;
    for (int k = 0; k < 300; k++) step("sat");
    check("sat_const", ch_cnt, 32'hFF00_0000);

    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_yq", 32'(y_q), 32'd0);
    check("arst_cnt", ch_cnt, 32'd0);
    check("arst_y_hold", 32'(y), 32'h8);
    sel = 2'b00;
    #1;
    check("arst_y_follow", 32'(y), 32'h1);
    rst_n = 1'b1;
    din = 1'b0;

    // Randomized cycles against the model.
    for (int k = 0; k < 1000; k++) begin
      din     = 1'($urandom_range(0, 1));
      sel     = 2'($urandom_range(0, 3));
      cnt_clr = ($urandom_range(0, 31) == 0) ? 1'b1 : 1'b0;
      #1;
      check("rnd_y", 32'(y), 32'(exp_y(din, sel)));
      check("rnd_onehot0", 32'($onehot0(y)), 32'd1);
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
